quant_block_scheduler: RTL and testbench

- Shares one luma and one chroma quantizer lane between three component block buffers: Y (luma), Cb and Cr (chroma).
- Arbitrates round-robin between the buffers' block-ready requests.
- Streams the granted buffer's 64 DCT coefficients, with their in-block index, onto the quantizer input bus, then frees the buffer.
- Sits between the 2-D DCT block buffers and the quantizers.

---
 rtl/quant_block_scheduler.sv | 168 ++++++++++++++++
 tb/tb_quant_block_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/quant_block_scheduler.sv
// Round-robin scheduler streaming 8x8 DCT blocks from Y/Cb/Cr buffers into shared luma/chroma quantizer lanes.
// Build option: define QUANT_SCHED_ZIGZAG_EN to read coefficients in JPEG zigzag order instead of raster order.
module quant_block_scheduler #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned NUM_REQ    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   output logic [NUM_REQ-1:0]    done,
   output logic [NUM_REQ-1:0]    grant,
   output logic [5:0]            rd_addr,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  dst_ready,
   output logic                  q_en,
   output logic [5:0]            q_addr,
   output logic [DATA_WIDTH-1:0] q_data,
   output logic                  q_chroma,
   output logic                  busy
);

   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned ADDR_W = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2
   } state_e;

`ifdef QUANT_SCHED_ZIGZAG_EN
   localparam logic [ADDR_W-1:0] ZIGZAG [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   function automatic logic [ADDR_W-1:0] ordering(input logic [ADDR_W-1:0] cnt);
      return ZIGZAG[cnt];
   endfunction
`else
   function automatic logic [ADDR_W-1:0] ordering(input logic [ADDR_W-1:0] cnt);
      return cnt;
   endfunction
`endif

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   count_q, count_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    gidx_q, gidx_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic                busy_q, busy_d;
   logic                q_chroma_q, q_chroma_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                q_en_q, q_en_d;
   logic [ADDR_W-1:0]   q_addr_q, q_addr_d;

   logic                arb_found;
   logic [IDX_W-1:0]    arb_idx;
   logic [IDX_W-1:0]    cand;

   // First requester at or after the round-robin pointer, cyclically.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
         if (!arb_found && req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      ptr_d      = ptr_q;
      gidx_d     = gidx_q;
      grant_d    = grant_q;
      done_d     = '0;
      busy_d     = busy_q;
      q_chroma_d = q_chroma_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = '0;
      // Quantizer bus trails the buffer read strobe by one cycle.
      q_en_d     = rd_en_q;
      q_addr_d   = rd_addr_q;

      unique case (state_q)
         IDLE: begin
            if (arb_found && dst_ready) begin
               gidx_d     = arb_idx;
               grant_d    = NUM_REQ'(1) << arb_idx;
               busy_d     = 1'b1;
               q_chroma_d = (arb_idx != '0);
               count_d    = '0;
               state_d    = READ;
            end
         end
         READ: begin
            rd_en_d   = 1'b1;
            rd_addr_d = ordering(count_q);
            count_d   = count_q + ADDR_W'(1);
            if (count_q == ADDR_W'(63)) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            done_d  = grant_q;
            ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         ptr_q      <= '0;
         gidx_q     <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         q_chroma_q <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         q_en_q     <= 1'b0;
         q_addr_q   <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         ptr_q      <= ptr_d;
         gidx_q     <= gidx_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         q_chroma_q <= q_chroma_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         q_en_q     <= q_en_d;
         q_addr_q   <= q_addr_d;
      end
   end

   assign grant    = grant_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign q_chroma = q_chroma_q;
   assign rd_en    = rd_en_q;
   assign rd_addr  = rd_addr_q;
   assign q_en     = q_en_q;
   assign q_addr   = q_addr_q;
   // Buffer data arrives aligned with the delayed strobe; zeroed when idle.
   assign q_data   = q_en_q ? rd_data : '0;

endmodule

// File: tb/tb_quant_block_scheduler.sv
// Directed bench for quant_block_scheduler: arbitration order, block streaming, dst_ready gating, mid-block reset.
module tb_quant_block_scheduler;

   localparam int unsigned DW = 10;
   localparam int unsigned NR = 3;

   logic          clk;
   logic          rst;
   logic [NR-1:0] req;
   logic [NR-1:0] done;
   logic [NR-1:0] grant;
   logic [5:0]    rd_addr;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          dst_ready;
   logic          q_en;
   logic [5:0]    q_addr;
   logic [DW-1:0] q_data;
   logic          q_chroma;
   logic          busy;

   int errors;
   int checks;

   quant_block_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .grant     (grant),
      .rd_addr   (rd_addr),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .dst_ready (dst_ready),
      .q_en      (q_en),
      .q_addr    (q_addr),
      .q_data    (q_data),
      .q_chroma  (q_chroma),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Block buffer: registered read returning address - 32.
   initial rd_data = '0;
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= DW'(rd_addr) - DW'(32);
   end

`ifdef QUANT_SCHED_ZIGZAG_EN
   logic [5:0] zz_tab [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };
   function automatic logic [5:0] exp_order(input int k);
      return zz_tab[k];
   endfunction
`else
   function automatic logic [5:0] exp_order(input int k);
      return 6'(k);
   endfunction
`endif

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after the grant edge; returns just after the first idle edge following the block.
   task automatic run_block(input logic [NR-1:0] g, input logic ch, input logic [NR-1:0] drop);
      logic [63:0] seen;
      logic [5:0]  ea;
      logic [DW-1:0] ed;
      seen = '0;
      check_eq("grant_issue", 64'(grant), 64'(g));
      check_eq("busy_issue", 64'(busy), 64'd1);
      check_eq("chroma_issue", 64'(q_chroma), 64'(ch));
      check_eq("q_en_at_grant", 64'(q_en), 64'd0);
      tick();
      check_eq("rd_en_first", 64'(rd_en), 64'd1);
      check_eq("rd_addr_first", 64'(rd_addr), 64'(exp_order(0)));
      check_eq("q_en_pre", 64'(q_en), 64'd0);
      for (int k = 0; k < 64; k++) begin
         tick();
         ea = exp_order(k);
         ed = DW'(ea) - DW'(32);
         check_eq("q_en", 64'(q_en), 64'd1);
         check_eq("q_addr", 64'(q_addr), 64'(ea));
         check_eq("q_data", 64'(q_data), 64'(ed));
         check_eq("q_chroma", 64'(q_chroma), 64'(ch));
         check_eq("grant_hold", 64'(grant), (k < 63) ? 64'(g) : 64'd0);
         check_eq("done", 64'(done), (k == 63) ? 64'(g) : 64'd0);
         seen[q_addr] = 1'b1;
      end
      req = req & ~drop;
      check_eq("perm", seen, {64{1'b1}});
      tick();
      check_eq("q_en_after", 64'(q_en), 64'd0);
      check_eq("done_after", 64'(done), 64'd0);
      check_eq("q_data_idle", 64'(q_data), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      req       = '0;
      dst_ready = 1'b0;
      tick();
      tick();
      check_eq("rst_grant", 64'(grant), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_rd_en", 64'(rd_en), 64'd0);
      check_eq("rst_q_en", 64'(q_en), 64'd0);
      check_eq("rst_addr", 64'({rd_addr, q_addr}), 64'd0);
      check_eq("rst_q_data", 64'(q_data), 64'd0);
      check_eq("rst_chroma", 64'(q_chroma), 64'd0);

      // Single luma block.
      rst = 1'b0;
      req = 3'b001;
      dst_ready = 1'b1;
      tick();
      run_block(3'b001, 1'b0, 3'b001);
      check_eq("idle_grant", 64'(grant), 64'd0);
      check_eq("idle_busy", 64'(busy), 64'd0);

      // All three requesting continuously: Y, Cb, Cr, Y back to back.
      do_reset();
      req = 3'b111;
      tick();
      run_block(3'b001, 1'b0, 3'b000);
      run_block(3'b010, 1'b1, 3'b000);
      run_block(3'b100, 1'b1, 3'b000);
      run_block(3'b001, 1'b0, 3'b111);
      check_eq("rr_end_grant", 64'(grant), 64'd0);

      // dst_ready gating, then dropped once the block is running.
      do_reset();
      dst_ready = 1'b0;
      req = 3'b010;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_eq("gated_grant", 64'(grant), 64'd0);
         check_eq("gated_busy", 64'(busy), 64'd0);
      end
      dst_ready = 1'b1;
      tick();
      dst_ready = 1'b0;
      run_block(3'b010, 1'b1, 3'b010);
      dst_ready = 1'b1;

      // Reset in the middle of a Cr block.
      do_reset();
      req = 3'b100;
      tick();
      check_eq("cr_grant", 64'(grant), 64'b100);
      for (int i = 0; i < 30; i++) tick();
      check_eq("cr_mid_q_en", 64'(q_en), 64'd1);
      rst = 1'b1;
      tick();
      check_eq("abort_grant", 64'(grant), 64'd0);
      check_eq("abort_done", 64'(done), 64'd0);
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_rd_en", 64'(rd_en), 64'd0);
      check_eq("abort_q_en", 64'(q_en), 64'd0);
      check_eq("abort_addr", 64'({rd_addr, q_addr}), 64'd0);
      check_eq("abort_q_data", 64'(q_data), 64'd0);
      check_eq("abort_chroma", 64'(q_chroma), 64'd0);
      rst = 1'b0;
      tick();
      run_block(3'b100, 1'b1, 3'b100);
      check_eq("final_grant", 64'(grant), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
